// File: rtl/execute_cycle_mx_if.sv
// Decode/hazard-side inputs and E->M register outputs of the RV32IM execute stage.
// The stage drives the slave side; the decode/hazard logic drives the master side.
interface execute_cycle_mx_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               FlushE;
  logic               RegWriteE;
  logic               MemWriteE;
  logic [1:0]         ResultSrcE;
  logic               ALUSrcE;
  logic [3:0]         ALUControlE;
  logic               BranchE;
  logic [2:0]         Funct3E;
  logic               JumpE;
  logic               JalrE;
  logic               MulDivE;
  logic [XLEN-1:0]    RD1_E;
  logic [XLEN-1:0]    RD2_E;
  logic [XLEN-1:0]    Imm_Ext_E;
  logic [RADDR_W-1:0] RD_E;
  logic [XLEN-1:0]    PCE;
  logic [XLEN-1:0]    PCPlus4E;
  logic [XLEN-1:0]    ResultW;
  logic [1:0]         ForwardA_E;
  logic [1:0]         ForwardB_E;

  logic               BusyE;
  logic               PCSrcE;
  logic [XLEN-1:0]    PCTargetE;
  logic               RegWriteM;
  logic               MemWriteM;
  logic [1:0]         ResultSrcM;
  logic [RADDR_W-1:0] RD_M;
  logic [XLEN-1:0]    ALU_ResultM;
  logic [XLEN-1:0]    WriteDataM;
  logic [XLEN-1:0]    PCPlus4M;

  modport master (
    output FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUControlE,
           BranchE, Funct3E, JumpE, JalrE, MulDivE, RD1_E, RD2_E, Imm_Ext_E,
           RD_E, PCE, PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
    input  BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, ALUControlE,
           BranchE, Funct3E, JumpE, JalrE, MulDivE, RD1_E, RD2_E, Imm_Ext_E,
           RD_E, PCE, PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
    output BusyE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_cycle_mx.sv
// RV32IM execute stage: forwarding, ALU, branch/jump resolution, iterative
// multiply/divide that stalls the pipeline, and the E->M pipeline register.
module execute_cycle_mx #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  execute_cycle_mx_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SH_W  = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  md_state_t        state_r, state_n_s;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  hi_r, lo_r, mcand_r, a_raw_r, b_raw_r;
  logic [2:0]       op_r;
  logic             neg_a_r, neg_b_r;

  logic [XLEN-1:0]  src_a_s, src_b_i_s, src_b_s, alu_res_s;
  logic [SH_W-1:0]  shamt_s;
  logic             eq_s, lt_s, ltu_s, taken_s;
  logic [XLEN-1:0]  jalr_sum_s;
  logic             busy_s, start_s, step_s;

  // Operand A forwarding mux
  always_comb begin
    case (bus.ForwardA_E)
      2'b00:   src_a_s = bus.RD1_E;
      2'b01:   src_a_s = bus.ResultW;
      2'b10:   src_a_s = bus.ALU_ResultM;
      default: src_a_s = bus.RD1_E;
    endcase
  end

  // Operand B forwarding mux
  always_comb begin
    case (bus.ForwardB_E)
      2'b00:   src_b_i_s = bus.RD2_E;
      2'b01:   src_b_i_s = bus.ResultW;
      2'b10:   src_b_i_s = bus.ALU_ResultM;
      default: src_b_i_s = bus.RD2_E;
    endcase
  end

  assign src_b_s = bus.ALUSrcE ? bus.Imm_Ext_E : src_b_i_s;
  assign shamt_s = src_b_s[SH_W-1:0];
  assign eq_s    = (src_a_s == src_b_s);
  assign lt_s    = ($signed(src_a_s) < $signed(src_b_s));
  assign ltu_s   = (src_a_s < src_b_s);

  // ALU
  always_comb begin
    case (bus.ALUControlE)
      4'd0:    alu_res_s = src_a_s + src_b_s;
      4'd1:    alu_res_s = src_a_s - src_b_s;
      4'd2:    alu_res_s = src_a_s & src_b_s;
      4'd3:    alu_res_s = src_a_s | src_b_s;
      4'd4:    alu_res_s = src_a_s ^ src_b_s;
      4'd5:    alu_res_s = {{(XLEN-1){1'b0}}, lt_s};
      4'd6:    alu_res_s = {{(XLEN-1){1'b0}}, ltu_s};
      4'd7:    alu_res_s = src_a_s << shamt_s;
      4'd8:    alu_res_s = src_a_s >> shamt_s;
      4'd9:    alu_res_s = $unsigned($signed(src_a_s) >>> shamt_s);
      default: alu_res_s = X_ZERO;
    endcase
  end

  // Branch condition
  always_comb begin
    case (bus.Funct3E)
      3'b000:  taken_s = eq_s;
      3'b001:  taken_s = ~eq_s;
      3'b100:  taken_s = lt_s;
      3'b101:  taken_s = ~lt_s;
      3'b110:  taken_s = ltu_s;
      3'b111:  taken_s = ~ltu_s;
      default: taken_s = 1'b0;
    endcase
  end

  assign jalr_sum_s    = src_a_s + bus.Imm_Ext_E;
  assign bus.PCSrcE    = ((bus.BranchE & taken_s) | bus.JumpE) & ~bus.FlushE & ~rst;
  assign bus.PCTargetE = bus.JalrE ? (jalr_sum_s & {{(XLEN-1){1'b1}}, 1'b0})
                                   : (bus.PCE + bus.Imm_Ext_E);

  // Operand sign handling at muldiv start: iterate on magnitudes, fix sign at the end
  logic            is_div_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;

  assign is_div_s   = bus.Funct3E[2];
  assign a_signed_s = is_div_s ? ~bus.Funct3E[0]
                               : (bus.Funct3E[1:0] == 2'b01) | (bus.Funct3E[1:0] == 2'b10);
  assign b_signed_s = is_div_s ? ~bus.Funct3E[0] : (bus.Funct3E[1:0] == 2'b01);
  assign a_neg_s    = a_signed_s & src_a_s[XLEN-1];
  assign b_neg_s    = b_signed_s & src_b_i_s[XLEN-1];
  assign a_mag_s    = a_neg_s ? (X_ZERO - src_a_s) : src_a_s;
  assign b_mag_s    = b_neg_s ? (X_ZERO - src_b_i_s) : src_b_i_s;

  // One shift-add multiply step and one restoring-divide step
  logic [XLEN:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic            div_ok_s;
  logic [XLEN-1:0] step_hi_s, step_lo_s;

  assign mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
  assign div_sh_s   = {hi_r, lo_r[XLEN-1]};
  assign div_diff_s = div_sh_s - {1'b0, mcand_r};
  assign div_ok_s   = ~div_diff_s[XLEN];
  assign step_hi_s  = op_r[2] ? (div_ok_s ? div_diff_s[XLEN-1:0] : div_sh_s[XLEN-1:0])
                              : mul_sum_s[XLEN:1];
  assign step_lo_s  = op_r[2] ? {lo_r[XLEN-2:0], div_ok_s}
                              : {mul_sum_s[0], lo_r[XLEN-1:1]};

  // Sign-corrected muldiv result
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, md_result_s;
  logic              div0_s;

  assign prod_s     = {hi_r, lo_r};
  assign prod_fix_s = (neg_a_r ^ neg_b_r) ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
  assign quo_fix_s  = (neg_a_r ^ neg_b_r) ? (X_ZERO - lo_r) : lo_r;
  assign rem_fix_s  = neg_a_r ? (X_ZERO - hi_r) : hi_r;
  assign div0_s     = (b_raw_r == X_ZERO);

  // Muldiv result select
  always_comb begin
    case (op_r)
      3'b000:          md_result_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          md_result_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:  md_result_s = div0_s ? X_ONES : quo_fix_s;
      3'b110, 3'b111:  md_result_s = div0_s ? a_raw_r : rem_fix_s;
      default:         md_result_s = X_ZERO;
    endcase
  end

  // Muldiv FSM next state and stall control; flush and reset override everything
  always_comb begin
    state_n_s = state_r;
    busy_s    = 1'b0;
    start_s   = 1'b0;
    step_s    = 1'b0;
    if (bus.FlushE || rst) begin
      state_n_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.MulDivE) begin
            busy_s    = 1'b1;
            start_s   = 1'b1;
            state_n_s = S_BUSY;
          end else begin
            state_n_s = S_IDLE;
          end
        end
        S_BUSY: begin
          busy_s = 1'b1;
          step_s = 1'b1;
          if (cnt_r == CNT_ONE) begin
            state_n_s = S_DONE;
          end else begin
            state_n_s = S_BUSY;
          end
        end
        S_DONE:  state_n_s = S_IDLE;
        default: state_n_s = S_IDLE;
      endcase
    end
  end

  assign bus.BusyE = busy_s;

  // Muldiv FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Muldiv operand latch, iteration counter and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      hi_r    <= X_ZERO;
      lo_r    <= X_ZERO;
      mcand_r <= X_ZERO;
      a_raw_r <= X_ZERO;
      b_raw_r <= X_ZERO;
      op_r    <= 3'b000;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
    end else if (bus.FlushE) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      cnt_r   <= CNT_LOAD;
      hi_r    <= X_ZERO;
      lo_r    <= is_div_s ? a_mag_s : b_mag_s;
      mcand_r <= is_div_s ? b_mag_s : a_mag_s;
      a_raw_r <= src_a_s;
      b_raw_r <= src_b_i_s;
      op_r    <= bus.Funct3E;
      neg_a_r <= a_neg_s;
      neg_b_r <= b_neg_s;
    end else if (step_s) begin
      cnt_r <= cnt_r - CNT_ONE;
      hi_r  <= step_hi_s;
      lo_r  <= step_lo_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // E->M pipeline register: bubble on flush or stall, muldiv result in DONE, else ALU path.
  // Control fields in DONE come from the E inputs, which upstream holds while stalled.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE || busy_s) begin
      bus.RegWriteM   <= 1'b0;
      bus.MemWriteM   <= 1'b0;
      bus.ResultSrcM  <= 2'b00;
      bus.RD_M        <= {RADDR_W{1'b0}};
      bus.ALU_ResultM <= X_ZERO;
      bus.WriteDataM  <= X_ZERO;
      bus.PCPlus4M    <= X_ZERO;
    end else begin
      bus.RegWriteM   <= bus.RegWriteE;
      bus.MemWriteM   <= bus.MemWriteE;
      bus.ResultSrcM  <= bus.ResultSrcE;
      bus.RD_M        <= bus.RD_E;
      bus.ALU_ResultM <= (state_r == S_DONE) ? md_result_s : alu_res_s;
      bus.WriteDataM  <= (state_r == S_DONE) ? b_raw_r : src_b_i_s;
      bus.PCPlus4M    <= bus.PCPlus4E;
    end
  end
endmodule
